// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcode/funct values and instruction field
// bit positions, plus the pipeline control modes driven by the hazard unit.
package mips_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_STALL,
    CTRL_FLUSH
  } ctrl_mode_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction and instruction-class decode for the word in
// IF/ID; shared by the hazard unit and the ID control unit.
module instr_field_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        is_load,
  output logic        is_muldiv,
  output logic        is_hilo_use
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[OP_MSB:OP_LSB];
  assign funct = instr[FUNCT_MSB:FUNCT_LSB];
  assign rs    = instr[RS_MSB:RS_LSB];
  assign rt    = instr[RT_MSB:RT_LSB];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    is_muldiv = 1'b0;
    is_hilo_use = 1'b0;
    if (op == OP_RTYPE) begin
      unique case (funct)
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_muldiv = 1'b1;
        FN_MFHI, FN_MFLO:                   is_hilo_use = 1'b1;
        default: ;
      endcase
    end
    is_hilo_use = is_hilo_use | is_muldiv;
  end

  assign is_load = (op == OP_LW);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use and HI/LO interlock for the 5-stage MIPS pipeline: holds IF/ID and
// the PC, bubbles ID/EX, and flushes IF/ID on a taken branch resolved in EX.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_id,
  input  logic             branch_taken_ex,
  output logic             if_id_enable,
  output logic             pc_enable,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_W = $clog2(MULDIV_LAT + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT);

  logic [4:0]      rs, rt;
  logic            is_load, is_muldiv, is_hilo_use;
  logic            ex_load_valid;
  logic [4:0]      ex_load_dst;
  logic [MD_W-1:0] md_cnt;
  logic            load_hazard, md_hazard;
  ctrl_mode_e      mode;
  logic            issue;

  instr_field_decode u_decode (
    .instr       (instr_id),
    .rs          (rs),
    .rt          (rt),
    .is_load     (is_load),
    .is_muldiv   (is_muldiv),
    .is_hilo_use (is_hilo_use)
  );

  // rs and rt are both compared regardless of opcode; the odd extra stall is accepted.
  assign load_hazard = ex_load_valid && (ex_load_dst != 5'd0) &&
                       ((rs == ex_load_dst) || (rt == ex_load_dst));
  assign md_hazard   = (md_cnt != '0) && is_hilo_use;
  assign md_busy     = (md_cnt != '0);

  always_comb begin
    mode = CTRL_RUN;
    if (branch_taken_ex)                mode = CTRL_FLUSH;
    else if (load_hazard || md_hazard)  mode = CTRL_STALL;
  end

  assign issue = (mode == CTRL_RUN);

  // While reset is asserted the pipeline is forced to run, whatever is in EX.
  always_comb begin
    if_id_enable = 1'b1;
    pc_enable    = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!reset) begin
      unique case (mode)
        CTRL_FLUSH: begin
          id_ex_bubble = 1'b1;
          if_id_flush  = 1'b1;
        end
        CTRL_STALL: begin
          if_id_enable = 1'b0;
          pc_enable    = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_load_valid <= 1'b0;
      ex_load_dst   <= 5'd0;
      md_cnt        <= '0;
      stall_cycles  <= '0;
    end else begin
      ex_load_valid <= issue && is_load;
      ex_load_dst   <= rt;
      // A flushed mult/div never issues; an older one keeps counting down.
      if (issue && is_muldiv)  md_cnt <= MD_LOAD;
      else if (md_cnt != '0)   md_cnt <= md_cnt - 1'b1;
      if ((mode == CTRL_STALL) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, HI/LO interlock, flush
// priority, asynchronous reset and counter saturation (second instance, CNT_W=4).
module tb_hazard_stall_ctrl;

  localparam logic [3:0] RUN   = 4'b1100;  // {if_id_enable, pc_enable, id_ex_bubble, if_id_flush}
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1111;

  localparam logic [31:0] I_LW8     = 32'h8C08_0000;  // lw   $8,0($0)
  localparam logic [31:0] I_LW0     = 32'h8C00_0000;  // lw   $0,0($0)
  localparam logic [31:0] I_ADD_88  = 32'h0108_4820;  // add  $9,$8,$8
  localparam logic [31:0] I_ADD_00  = 32'h0000_4820;  // add  $9,$0,$0
  localparam logic [31:0] I_MULT    = 32'h0109_0018;  // mult $8,$9
  localparam logic [31:0] I_MFLO    = 32'h0000_5012;  // mflo $10

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_id;
  logic        branch_taken_ex;
  logic        if_id_enable, pc_enable, id_ex_bubble, if_id_flush, md_busy;
  logic [15:0] stall_cycles;
  logic        s_if_id_enable, s_pc_enable, s_id_ex_bubble, s_if_id_flush, s_md_busy;
  logic [3:0]  s_stall_cycles;
  logic [3:0]  ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .instr_id        (instr_id),
    .branch_taken_ex (branch_taken_ex),
    .if_id_enable    (if_id_enable),
    .pc_enable       (pc_enable),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .md_busy         (md_busy),
    .stall_cycles    (stall_cycles)
  );

  hazard_stall_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .instr_id        (instr_id),
    .branch_taken_ex (branch_taken_ex),
    .if_id_enable    (s_if_id_enable),
    .pc_enable       (s_pc_enable),
    .id_ex_bubble    (s_id_ex_bubble),
    .if_id_flush     (s_if_id_flush),
    .md_busy         (s_md_busy),
    .stall_cycles    (s_stall_cycles)
  );

  assign ctl = {if_id_enable, pc_enable, id_ex_bubble, if_id_flush};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic br);
    instr_id = instr;
    branch_taken_ex = br;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_id = 32'h0;
    branch_taken_ex = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_id = I_ADD_88;
    branch_taken_ex = 1'b0;
    #2;
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RUN); end
    checks++;
    if (md_busy !== 1'b0 || stall_cycles !== 16'd0) begin
      failures++; $display("FAIL reset_state md_busy=%b stall_cycles=%0d exp 0/0", md_busy, stall_cycles);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(I_LW8, 1'b0);
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL lw_issue got=%b exp=%b", ctl, RUN); end
    tick();
    drive(I_ADD_88, 1'b0);
    checks++;
    if (ctl !== STALL) begin failures++; $display("FAIL load_use_stall got=%b exp=%b", ctl, STALL); end
    tick();
    drive(I_ADD_88, 1'b0);
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL load_use_resume got=%b exp=%b", ctl, RUN); end
    checks++;
    if (stall_cycles !== 16'd1) begin failures++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles); end
    tick();
  endtask

  task automatic test_load_r0();
    do_reset();
    drive(I_LW0, 1'b0);
    tick();
    drive(I_ADD_00, 1'b0);
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL load_r0_nostall got=%b exp=%b", ctl, RUN); end
    tick();
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL load_r0_count got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_muldiv();
    do_reset();
    drive(I_MULT, 1'b0);
    checks++;
    if (ctl !== RUN || md_busy !== 1'b0) begin
      failures++; $display("FAIL mult_issue ctl=%b md_busy=%b exp %b/0", ctl, md_busy, RUN);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(I_MFLO, 1'b0);
      checks++;
      if (ctl !== STALL || md_busy !== 1'b1) begin
        failures++; $display("FAIL mflo_wait[%0d] ctl=%b md_busy=%b exp %b/1", i, ctl, md_busy, STALL);
      end
      tick();
    end
    drive(I_MFLO, 1'b0);
    checks++;
    if (ctl !== RUN || md_busy !== 1'b0) begin
      failures++; $display("FAIL mflo_issue ctl=%b md_busy=%b exp %b/0", ctl, md_busy, RUN);
    end
    checks++;
    if (stall_cycles !== 16'd4) begin failures++; $display("FAIL muldiv_count got=%0d exp=4", stall_cycles); end
    tick();
  endtask

  task automatic test_flush_priority();
    do_reset();
    drive(I_LW8, 1'b0);
    tick();
    drive(I_ADD_88, 1'b1);
    checks++;
    if (ctl !== FLUSH) begin failures++; $display("FAIL flush_over_stall got=%b exp=%b", ctl, FLUSH); end
    tick();
    drive(I_ADD_88, 1'b0);
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL flush_no_residual got=%b exp=%b", ctl, RUN); end
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", stall_cycles); end
    tick();
    // A mult/div sitting in ID when the flush hits must not start the HI/LO timer.
    drive(I_MULT, 1'b1);
    tick();
    drive(I_MFLO, 1'b0);
    checks++;
    if (ctl !== RUN || md_busy !== 1'b0) begin
      failures++; $display("FAIL flushed_mult ctl=%b md_busy=%b exp %b/0", ctl, md_busy, RUN);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(I_MULT, 1'b0);
    tick();
    drive(I_MFLO, 1'b0);
    tick();
    tick();
    checks++;
    if (ctl !== STALL || md_busy !== 1'b1 || stall_cycles !== 16'd2) begin
      failures++; $display("FAIL pre_reset ctl=%b md_busy=%b cnt=%0d exp %b/1/2", ctl, md_busy, stall_cycles, STALL);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== RUN || md_busy !== 1'b0 || stall_cycles !== 16'd0) begin
      failures++; $display("FAIL async_reset ctl=%b md_busy=%b cnt=%0d exp %b/0/0", ctl, md_busy, stall_cycles, RUN);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== RUN) begin failures++; $display("FAIL post_reset_run got=%b exp=%b", ctl, RUN); end
    tick();
  endtask

  task automatic test_saturation();
    // Holding mult in ID: issue, 4 stalls, reissue... -> 24 edges give 19 stalls.
    do_reset();
    drive(I_MULT, 1'b0);
    repeat (18) tick();
    checks++;
    if (s_stall_cycles !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", s_stall_cycles); end
    repeat (6) tick();
    checks++;
    if (s_stall_cycles !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0d exp=15", s_stall_cycles); end
    checks++;
    if (stall_cycles !== 16'd19) begin failures++; $display("FAIL sat_wide got=%0d exp=19", stall_cycles); end
  endtask

  initial begin
    reset = 1'b1;
    instr_id = 32'h0;
    branch_taken_ex = 1'b0;
    test_reset();
    test_load_use();
    test_load_r0();
    test_muldiv();
    test_flush_priority();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
